nabp_multi_swap_control: RTL
============================

NABP_MULTI_SWAP_CONTROL -- requirements
Module: nabp_multi_swap_control

Interface
REQ-001 Parameter NUM_SW, default 3: number of swappable buffers in the ring, legal 2..8.
REQ-002 Parameter SEL_W, default 2: index width, SHALL equal ceil(log2(NUM_SW)).
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 kick  input  1  start of one projection-set run.
REQ-006 prep_done  input  1  preprocess stage finished.
REQ-007 has_next_angle  input  1  angle generator holds a further angle.
REQ-008 next_angle_ack  output  1  one-cycle pulse consuming an angle.
REQ-009 sw_swap_ready  input  NUM_SW  per-buffer fill complete.
REQ-010 sw_next_itr  input  NUM_SW  per-buffer shift-out complete.
REQ-011 sw_swap  output  NUM_SW  one-hot swap command.
REQ-012 sw_next_itr_ack  output  NUM_SW  one-hot retire acknowledge.
REQ-013 fill_sel  output  SEL_W  index of buffer being filled.
REQ-014 drain_sel  output  SEL_W  index of oldest shifting buffer.
REQ-015 pe_kick  output  1  one-cycle pulse when PEs start from empty.
REQ-016 pe_en  output  1  PE enable, high while any buffer is shifting.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 done  output  1  one-cycle pulse at end of run.

Function
REQ-019 States SHALL be IDLE, PREP, FILL, DRAIN, plus a registered occupancy count occ (0..NUM_SW) of swapped-in, unretired buffers.
REQ-020 IDLE->PREP on kick; kick outside IDLE SHALL be ignored.
REQ-021 PREP->FILL on prep_done.
REQ-022 swap = (state==FILL) & sw_swap_ready[fill_sel] & (occ<NUM_SW); Mealy, same cycle; sw_swap[fill_sel]=swap, other bits 0.
REQ-023 On swap: fill_sel advances by one, wrapping NUM_SW-1->0; if has_next_angle, next_angle_ack=1 same cycle and state stays FILL, else FILL->DRAIN.
REQ-024 retire = (occ!=0) & sw_next_itr[drain_sel]; sw_next_itr_ack[drain_sel]=retire, same cycle; drain_sel advances with same wrap.
REQ-025 occ: +1 on swap only, -1 on retire only, unchanged on both together.
REQ-026 sw_swap_ready/sw_next_itr bits at indices other than fill_sel/drain_sel SHALL be ignored.
REQ-027 FILL with occ==NUM_SW SHALL block swap (ring full) until a retire.
REQ-028 DRAIN->IDLE when occ==0 (counting the same-cycle retire), with done pulsed on that transition.
REQ-029 pe_en = (occ!=0), registered; pe_kick pulses for one cycle on the edge where occ goes 0->1.
REQ-030 Retires SHALL be honoured in any state with occ!=0.

Reset
REQ-031 reset SHALL asynchronously force state=IDLE, occ=0, fill_sel=0, drain_sel=0, pe_en=0, pe_kick=0, done=0, stall count=0.
REQ-032 While reset is high, all Mealy outputs (sw_swap, sw_next_itr_ack, next_angle_ack) SHALL be 0.
REQ-033 Reset mid-run SHALL abandon all buffers; no completion or ack is emitted for them.

Configuration
REQ-034 With NABP_SWAP_STALL_CNT_EN defined, the block SHALL add output stall_cnt (16 bits): it counts cycles in FILL with sw_swap_ready[fill_sel]=1 and occ==NUM_SW, saturates at 16'hFFFF, and clears on kick accepted and on reset.
REQ-035 Without NABP_SWAP_STALL_CNT_EN, the stall_cnt port and its logic SHALL be absent, with behaviour otherwise identical.

Verification (NUM_SW=3)
REQ-036 Kick, prep_done, ready[0] with has_next_angle=1 -> sw_swap=3'b001 and next_angle_ack same cycle; fill_sel=1; next cycle pe_kick=1, pe_en=1.
REQ-037 Three swaps with no retires, then ready[0] held -> no swap while occ=3; stall_cnt increments each cycle (macro on); next_itr[0] -> ack=3'b001, swap fires the cycle after.
REQ-038 Swap and retire in the same cycle at occ=2 -> occ stays 2; fill_sel and drain_sel both advance; wrap from 2 to 0 checked.
REQ-039 Last swap with has_next_angle=0 -> no next_angle_ack; DRAIN; after final retire, done pulses once and busy falls.
REQ-040 Assert reset mid-FILL with occ=2 -> outputs cleared immediately (asynchronously); a following kick restarts with fill_sel=0.
REQ-041 next_itr[2] while drain_sel=0, and kick while busy -> both ignored; no state change.

Source files
------------

// File: rtl/nabp_multi_swap_control.sv
// nabp_multi_swap_control
//   Sequences a ring of NUM_SW swappable projection buffers. One run goes
//   IDLE -> PREP -> FILL -> DRAIN -> IDLE. In FILL, buffers are filled and
//   swapped in one after another, in ring order. In any state, swapped-in
//   buffers are retired in the same order as the PEs finish shifting them
//   out.
//
// Optional feature: define NABP_SWAP_STALL_CNT_EN to add stall_cnt_o. It is
//   a saturating count of FILL cycles that were blocked because the ring was
//   full.
//
// Ports
//   clk                  rising-edge clock
//   reset                asynchronous, active-high reset
//   kick_i               start a projection-set run (honoured in IDLE only)
//   prep_done_i          preprocess stage finished (PREP -> FILL)
//   has_next_angle_i     angle generator holds a further angle
//   next_angle_ack_o     combinational pulse consuming an angle on a swap
//   sw_swap_ready_i      per-buffer fill complete
//   sw_next_itr_i        per-buffer shift-out complete
//   sw_swap_o            combinational one-hot swap command
//   sw_next_itr_ack_o    combinational one-hot retire acknowledge
//   fill_sel_o           index of the buffer being filled
//   drain_sel_o          index of the oldest shifting buffer
//   pe_kick_o            one-cycle pulse when the ring goes from empty to
//                        occupied
//   pe_en_o              high while any buffer is shifting
//   busy_o               high in every state except IDLE
//   done_o               one-cycle pulse when a run completes
//   stall_cnt_o          (NABP_SWAP_STALL_CNT_EN only) ring-full stall cycles

module nabp_multi_swap_control #(
  parameter int unsigned NUM_SW = 3,
  parameter int unsigned SEL_W  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              kick_i,
  input  logic              prep_done_i,
  input  logic              has_next_angle_i,
  output logic              next_angle_ack_o,
  input  logic [NUM_SW-1:0] sw_swap_ready_i,
  input  logic [NUM_SW-1:0] sw_next_itr_i,
  output logic [NUM_SW-1:0] sw_swap_o,
  output logic [NUM_SW-1:0] sw_next_itr_ack_o,
  output logic [SEL_W-1:0]  fill_sel_o,
  output logic [SEL_W-1:0]  drain_sel_o,
  output logic              pe_kick_o,
  output logic              pe_en_o,
  output logic              busy_o,
  output logic              done_o
`ifdef NABP_SWAP_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt_o
`endif
);

  localparam int unsigned      OCC_W    = $clog2(NUM_SW + 1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(NUM_SW);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_SW - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PREP  = 2'd1,
    FILL  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [SEL_W-1:0] fill_sel_q, fill_sel_d;
  logic [SEL_W-1:0] drain_sel_q, drain_sel_d;
  logic             pe_kick_q, pe_en_q, done_q;

  logic ready_sel_c, itr_sel_c;
  logic swap_c, retire_c, kick_acc_c;

  // Pick out only the ready/next_itr bits at the current ring pointers.
  always_comb begin
    ready_sel_c = 1'b0;
    itr_sel_c   = 1'b0;
    for (int i = 0; i < NUM_SW; i++) begin
      if (fill_sel_q == SEL_W'(i))  ready_sel_c = sw_swap_ready_i[i];
      if (drain_sel_q == SEL_W'(i)) itr_sel_c   = sw_next_itr_i[i];
    end
  end

  // The reset gating keeps the Mealy outputs quiet while reset is held.
  assign swap_c     = ~reset & (state_q == FILL) & ready_sel_c & (occ_q < OCC_FULL);
  assign retire_c   = ~reset & (occ_q != '0) & itr_sel_c;
  assign kick_acc_c = (state_q == IDLE) & kick_i;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (kick_i)                        state_d = PREP;
      PREP:    if (prep_done_i)                   state_d = FILL;
      FILL:    if (swap_c && !has_next_angle_i)   state_d = DRAIN;
      DRAIN:   if (occ_d == '0)                   state_d = IDLE;
      default:                                    state_d = IDLE;
    endcase
  end

  // Outputs and ring-pointer / occupancy next values.
  always_comb begin
    sw_swap_o         = '0;
    sw_next_itr_ack_o = '0;
    next_angle_ack_o  = 1'b0;
    fill_sel_d        = fill_sel_q;
    drain_sel_d       = drain_sel_q;
    occ_d             = occ_q;

    if (swap_c) begin
      sw_swap_o        = NUM_SW'(1) << fill_sel_q;
      next_angle_ack_o = has_next_angle_i;
      fill_sel_d       = (fill_sel_q == SEL_LAST) ? '0 : fill_sel_q + SEL_W'(1);
    end

    if (retire_c) begin
      sw_next_itr_ack_o = NUM_SW'(1) << drain_sel_q;
      drain_sel_d       = (drain_sel_q == SEL_LAST) ? '0 : drain_sel_q + SEL_W'(1);
    end

    // A swap and a retire in the same cycle leave occupancy unchanged.
    case ({swap_c, retire_c})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  // Datapath registers and registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ_q       <= '0;
      fill_sel_q  <= '0;
      drain_sel_q <= '0;
      pe_kick_q   <= 1'b0;
      pe_en_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      occ_q       <= occ_d;
      fill_sel_q  <= fill_sel_d;
      drain_sel_q <= drain_sel_d;
      pe_kick_q   <= (occ_q == '0) && (occ_d != '0);
      pe_en_q     <= (occ_d != '0);
      done_q      <= (state_q == DRAIN) && (state_d == IDLE);
    end
  end

  assign fill_sel_o  = fill_sel_q;
  assign drain_sel_o = drain_sel_q;
  assign pe_kick_o   = pe_kick_q;
  assign pe_en_o     = pe_en_q;
  assign done_o      = done_q;
  assign busy_o      = (state_q != IDLE);

`ifdef NABP_SWAP_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Count FILL cycles where a full buffer waits on a full ring; saturating.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (kick_acc_c)
      stall_cnt_d = '0;
    else if ((state_q == FILL) && ready_sel_c && (occ_q == OCC_FULL) &&
             (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  // kick_acc_c only feeds the stall counter.
  logic unused_kick_acc;
  assign unused_kick_acc = kick_acc_c;
`endif

endmodule
